// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-receiver and payload-stream signals of the UART frame controller.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface uart_rx_frame_ctrl_if;
   logic       i_RxDone;
   logic [7:0] i_RxByte;
   logic       i_FrameReady;
   logic [7:0] o_FrameData;
   logic       o_FrameValid;
   logic       o_FrameLast;
   logic       o_FrameOk;
   logic       o_FrameErr;
   logic [1:0] o_ErrCode;

   modport slave (
      input  i_RxDone,
      input  i_RxByte,
      input  i_FrameReady,
      output o_FrameData,
      output o_FrameValid,
      output o_FrameLast,
      output o_FrameOk,
      output o_FrameErr,
      output o_ErrCode
   );

   modport master (
      output i_RxDone,
      output i_RxByte,
      output i_FrameReady,
      input  o_FrameData,
      input  o_FrameValid,
      input  o_FrameLast,
      input  o_FrameOk,
      input  o_FrameErr,
      input  o_ErrCode
   );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame parser: SYNC 0x55, LEN, LEN payload bytes, CHK = (LEN + sum) mod 256.
// Payload leaves on a valid/ready stream; completion and abort are one-cycle pulses.
module uart_rx_frame_ctrl #(
   parameter int SYS_CLOCK     = 50000000,
   parameter int UART_BAUDRATE = 115200,
   parameter int MAX_LEN       = 16,
   parameter int TIMEOUT_BYTES = 2
) (
   input  logic                  i_SysClock,
   input  logic                  i_Reset,
   uart_rx_frame_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } state_t;

   localparam logic [7:0]  SYNC_BYTE    = 8'h55;
   localparam logic [7:0]  MAX_LEN8     = 8'(MAX_LEN);
   localparam int unsigned TO_LIMIT     = TIMEOUT_BYTES * 10 * (SYS_CLOCK / UART_BAUDRATE);
   localparam logic [31:0] TO_LAST      = 32'(TO_LIMIT - 1);
   localparam logic [1:0]  ERR_LEN      = 2'd0;
   localparam logic [1:0]  ERR_CHK      = 2'd1;
   localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0]  ERR_OVERFLOW = 2'd3;

   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      sum8 = a + b;
   endfunction

   state_t      state_q, state_d;
   logic        rx_done_q;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        ok_q, ok_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic [31:0] timer_q, timer_d;

   logic strobe_s, accept_s, timeout_s, len_bad_s, overflow_s;

   assign strobe_s   = bus.i_RxDone & ~rx_done_q;
   assign accept_s   = valid_q & bus.i_FrameReady;
   assign timeout_s  = (state_q != ST_IDLE) && !strobe_s && (timer_q == TO_LAST);
   assign len_bad_s  = (bus.i_RxByte == 8'd0) || (bus.i_RxByte > MAX_LEN8);
   // A new payload byte while the previous one is still unaccepted cannot be stored.
   assign overflow_s = valid_q & ~bus.i_FrameReady;

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (strobe_s) begin
         case (state_q)
            ST_IDLE:    state_d = (bus.i_RxByte == SYNC_BYTE) ? ST_LEN : ST_IDLE;
            ST_LEN:     state_d = len_bad_s ? ST_IDLE : ST_PAYLOAD;
            ST_PAYLOAD: begin
               if (overflow_s) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == 8'd1) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end
            ST_CHK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end else if (timeout_s) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q & ~accept_s;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      // The gap timer only runs inside a frame and restarts on every byte.
      if ((state_q == ST_IDLE) || strobe_s || timeout_s) begin
         timer_d = 32'd0;
      end else begin
         timer_d = timer_q + 32'd1;
      end
      if (strobe_s) begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = 8'd0;
               sum_d = 8'd0;
            end
            ST_LEN: begin
               if (len_bad_s) begin
                  err_d  = 1'b1;
                  code_d = ERR_LEN;
               end else begin
                  cnt_d = bus.i_RxByte;
                  sum_d = bus.i_RxByte;
               end
            end
            ST_PAYLOAD: begin
               if (overflow_s) begin
                  err_d  = 1'b1;
                  code_d = ERR_OVERFLOW;
               end else begin
                  data_d  = bus.i_RxByte;
                  valid_d = 1'b1;
                  last_d  = (cnt_q == 8'd1);
                  sum_d   = sum8(sum_q, bus.i_RxByte);
                  cnt_d   = cnt_q - 8'd1;
               end
            end
            ST_CHK: begin
               if (bus.i_RxByte == sum_q) begin
                  ok_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CHK;
               end
            end
            default: begin
               cnt_d = 8'd0;
               sum_d = 8'd0;
            end
         endcase
      end else if (timeout_s) begin
         err_d  = 1'b1;
         code_d = ERR_TIMEOUT;
      end else begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         rx_done_q <= 1'b1;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 2'd0;
         cnt_q     <= 8'd0;
         sum_q     <= 8'd0;
         timer_q   <= 32'd0;
      end else begin
         rx_done_q <= bus.i_RxDone;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         timer_q   <= timer_d;
      end
   end

   assign bus.o_FrameData  = data_q;
   assign bus.o_FrameValid = valid_q;
   assign bus.o_FrameLast  = last_q;
   assign bus.o_FrameOk    = ok_q;
   assign bus.o_FrameErr   = err_q;
   assign bus.o_ErrCode    = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good frame, checksum, length, timeout,
// overflow and mid-frame reset scenarios with hand-computed expectations.
module tb_uart_rx_frame_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_frame_ctrl_if bus ();

   uart_rx_frame_ctrl #(
      .SYS_CLOCK     (1000000),
      .UART_BAUDRATE (100000),
      .MAX_LEN       (16),
      .TIMEOUT_BYTES (2)
   ) dut (
      .i_SysClock (clk),
      .i_Reset    (rst),
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;
   int ok_total = 0;
   int err_total = 0;
   logic both_seen = 1'b0;
   logic [8:0] acc_q[$];

   // Pulse counters and accepted-byte log ({last, data}), sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.o_FrameOk) ok_total <= ok_total + 1;
      if (bus.o_FrameErr) err_total <= err_total + 1;
      if (bus.o_FrameOk && bus.o_FrameErr) both_seen <= 1'b1;
      if (bus.o_FrameValid && bus.i_FrameReady) acc_q.push_back({bus.o_FrameLast, bus.o_FrameData});
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.i_RxByte = b;
      bus.i_RxDone = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.i_RxDone = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #2;
      bus.i_FrameReady = r;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast, bus.o_FrameOk, bus.o_FrameErr, bus.o_ErrCode} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h valid=%b last=%b ok=%b err=%b code=%0d expected all zero",
                  bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast, bus.o_FrameOk, bus.o_FrameErr, bus.o_ErrCode);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_good_frame;
      int b_ok = ok_total;
      int b_err = err_total;
      int b_acc = acc_q.size();
      send_byte(8'h55);
      send_byte(8'h02);
      send_byte(8'hA1);
      checks++;
      if (bus.o_FrameData !== 8'hA1 || bus.o_FrameValid !== 1'b1 || bus.o_FrameLast !== 1'b0) begin
         errors++;
         $display("FAIL good_a1: data=%h valid=%b last=%b expected a1 1 0", bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast);
      end
      send_byte(8'hB2);
      checks++;
      if (bus.o_FrameData !== 8'hB2 || bus.o_FrameValid !== 1'b1 || bus.o_FrameLast !== 1'b1) begin
         errors++;
         $display("FAIL good_b2: data=%h valid=%b last=%b expected b2 1 1", bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast);
      end
      send_byte(8'h55);
      checks++;
      if (bus.o_FrameOk !== 1'b1 || bus.o_FrameErr !== 1'b0) begin
         errors++;
         $display("FAIL good_ok_pulse: ok=%b err=%b expected 1 0", bus.o_FrameOk, bus.o_FrameErr);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ok_total - b_ok !== 1 || err_total - b_err !== 0) begin
         errors++;
         $display("FAIL good_counts: ok=%0d err=%0d expected 1 0", ok_total - b_ok, err_total - b_err);
      end
      checks++;
      if (acc_q.size() - b_acc !== 2 || acc_q[b_acc] !== 9'h0A1 || acc_q[b_acc + 1] !== 9'h1B2) begin
         errors++;
         $display("FAIL good_accepted: count=%0d expected 2 bytes a1, b2+last", acc_q.size() - b_acc);
      end
   endtask

   task automatic test_chk_error;
      int b_ok = ok_total;
      int b_acc = acc_q.size();
      send_byte(8'h55);
      send_byte(8'h02);
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'h00);
      checks++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_ErrCode !== 2'd1 || bus.o_FrameOk !== 1'b0) begin
         errors++;
         $display("FAIL chk_err: err=%b code=%0d ok=%b expected 1 1 0", bus.o_FrameErr, bus.o_ErrCode, bus.o_FrameOk);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ok_total - b_ok !== 0 || acc_q.size() - b_acc !== 2) begin
         errors++;
         $display("FAIL chk_counts: ok=%0d bytes=%0d expected 0 2", ok_total - b_ok, acc_q.size() - b_acc);
      end
   endtask

   task automatic test_bad_len;
      send_byte(8'h55);
      send_byte(8'h00);
      checks++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_ErrCode !== 2'd0) begin
         errors++;
         $display("FAIL len_zero: err=%b code=%0d expected 1 0", bus.o_FrameErr, bus.o_ErrCode);
      end
      send_byte(8'h55);
      send_byte(8'h11);
      checks++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_ErrCode !== 2'd0) begin
         errors++;
         $display("FAIL len_too_big: err=%b code=%0d expected 1 0", bus.o_FrameErr, bus.o_ErrCode);
      end
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h7E);
      checks++;
      if (bus.o_FrameData !== 8'h7E || bus.o_FrameLast !== 1'b1) begin
         errors++;
         $display("FAIL len_one_data: data=%h last=%b expected 7e 1", bus.o_FrameData, bus.o_FrameLast);
      end
      send_byte(8'h7F);
      checks++;
      if (bus.o_FrameOk !== 1'b1 || bus.o_FrameErr !== 1'b0) begin
         errors++;
         $display("FAIL len_recover_ok: ok=%b err=%b expected 1 0", bus.o_FrameOk, bus.o_FrameErr);
      end
   endtask

   task automatic test_timeout;
      int b_err;
      send_byte(8'h55);
      send_byte(8'h03);
      send_byte(8'h10);
      repeat (199) @(posedge clk);
      #1;
      checks++;
      if (bus.o_FrameErr !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: err=%b at clock 199 expected 0", bus.o_FrameErr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_ErrCode !== 2'd2) begin
         errors++;
         $display("FAIL timeout_fire: err=%b code=%0d at clock 200 expected 1 2", bus.o_FrameErr, bus.o_ErrCode);
      end
      b_err = err_total + 1;
      send_byte(8'h55);
      send_byte(8'h03);
      send_byte(8'h10);
      repeat (197) @(posedge clk);
      send_byte(8'h20);
      checks++;
      if (bus.o_FrameErr !== 1'b0 || bus.o_FrameData !== 8'h20 || bus.o_FrameValid !== 1'b1) begin
         errors++;
         $display("FAIL timeout_strobe_wins: err=%b data=%h valid=%b expected 0 20 1", bus.o_FrameErr, bus.o_FrameData, bus.o_FrameValid);
      end
      send_byte(8'h30);
      send_byte(8'h63);
      checks++;
      if (bus.o_FrameOk !== 1'b1) begin
         errors++;
         $display("FAIL timeout_frame_ok: ok=%b expected 1", bus.o_FrameOk);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err_total !== b_err) begin
         errors++;
         $display("FAIL timeout_err_count: err=%0d expected %0d", err_total, b_err);
      end
   endtask

   task automatic test_overflow;
      int b_err;
      int b_acc = acc_q.size();
      set_ready(1'b0);
      send_byte(8'h55);
      send_byte(8'h03);
      send_byte(8'h10);
      send_byte(8'h20);
      checks++;
      if (bus.o_FrameErr !== 1'b1 || bus.o_ErrCode !== 2'd3 || bus.o_FrameData !== 8'h10 || bus.o_FrameValid !== 1'b1) begin
         errors++;
         $display("FAIL overflow_err: err=%b code=%0d data=%h valid=%b expected 1 3 10 1",
                  bus.o_FrameErr, bus.o_ErrCode, bus.o_FrameData, bus.o_FrameValid);
      end
      b_err = err_total + 1;
      repeat (210) @(posedge clk);
      #1;
      checks++;
      if (err_total !== b_err || bus.o_FrameData !== 8'h10) begin
         errors++;
         $display("FAIL overflow_idle: err=%0d data=%h expected %0d 10", err_total, bus.o_FrameData, b_err);
      end
      set_ready(1'b1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.o_FrameValid !== 1'b0 || acc_q.size() - b_acc !== 1 || acc_q[acc_q.size() - 1] !== 9'h010) begin
         errors++;
         $display("FAIL overflow_accept: valid=%b accepted=%0d expected 0 1", bus.o_FrameValid, acc_q.size() - b_acc);
      end
   endtask

   task automatic test_reset_mid_frame;
      int b_ok = ok_total;
      int b_err = err_total;
      int b_acc = acc_q.size();
      send_byte(8'h55);
      send_byte(8'h02);
      send_byte(8'hA1);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast, bus.o_FrameOk, bus.o_FrameErr, bus.o_ErrCode} !== 14'd0) begin
         errors++;
         $display("FAIL midreset_async: data=%h valid=%b last=%b ok=%b err=%b code=%0d expected all zero",
                  bus.o_FrameData, bus.o_FrameValid, bus.o_FrameLast, bus.o_FrameOk, bus.o_FrameErr, bus.o_ErrCode);
      end
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'hB2);
      send_byte(8'h55);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (ok_total !== b_ok || err_total !== b_err || acc_q.size() !== b_acc || bus.o_FrameValid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_ignored: ok=%0d err=%0d bytes=%0d valid=%b expected no activity",
                  ok_total - b_ok, err_total - b_err, acc_q.size() - b_acc, bus.o_FrameValid);
      end
   endtask

   task automatic test_exclusive;
      checks++;
      if (both_seen !== 1'b0) begin
         errors++;
         $display("FAIL ok_err_exclusive: both pulses seen together=%b expected 0", both_seen);
      end
   endtask

   initial begin
      bus.i_RxDone     = 1'b1;
      bus.i_RxByte     = 8'h00;
      bus.i_FrameReady = 1'b1;
      test_reset();
      test_good_frame();
      test_chk_error();
      test_bad_len();
      test_timeout();
      test_overflow();
      test_reset_mid_frame();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
